ser_rx_ctrl: RTL

- Receive-side controller and shift register for the serial frame our start/strobe transmit controller produces.
- Frame on the line: a one-cycle `start` pulse, then WIDTH data bits on `sdi`, one bit per clock.
- The block captures the bits into a parallel word and pulses `valid` when the word is ready.
- Sits between the serial link and the downstream parallel register or display logic.

---
 rtl/ser_rx_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ser_rx_ctrl.sv
// -----------------------------------------------------------------------------
// ser_rx_ctrl
//   Receive-side controller and shift register for the start/strobe serial
//   frame. A one-cycle start pulse is followed by WIDTH data bits on sdi, one
//   per clock. The bits are assembled into a parallel word. valid pulses for
//   one cycle when dout is updated with the new word.
//
//   Optional build macro: SER_RX_PARITY_EN
//     When it is defined, each frame carries one even-parity bit after the
//     data bits. A frame with good parity produces valid. A frame with bad
//     parity produces err and leaves dout unchanged.
//     When it is undefined, no parity logic exists.
//
// Parameters
//   WIDTH      data bits per frame (2..31)
//   MSB_FIRST  1: first received bit -> dout[WIDTH-1]; 0: first bit -> dout[0]
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active-high
//   start  in   frame-start pulse, immediately precedes the first data bit
//   sdi    in   serial data, sampled on every edge while shifting
//   dout   out  last completed frame, held until the next valid
//   valid  out  one-cycle pulse, dout updated in the same cycle
//   busy   out  high while a frame is being shifted in
//   err    out  one-cycle pulse on a framing (or parity) error
// -----------------------------------------------------------------------------
module ser_rx_ctrl #(
   parameter int WIDTH     = 16,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sdi,
   output logic [WIDTH-1:0] dout,
   output logic             valid,
   output logic             busy,
   output logic             err
);

   // state   | meaning
   // S_IDLE  | waiting for start, sdi ignored
   // S_SHIFT | sampling one frame bit per edge
   // S_DONE  | one cycle; valid/err reported, start here begins the next frame
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef SER_RX_PARITY_EN
   // The extra edge after the data bits samples the parity bit.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   shift_q;
   logic [WIDTH-1:0]   shift_d;
   logic [WIDTH-1:0]   dout_q;
   logic               valid_q;
   logic               busy_q;
   logic               err_q;

   always_comb begin
      shift_d = shift_q;
      if (MSB_FIRST) begin
         shift_d = {shift_q[WIDTH-2:0], sdi};
      end else begin
         shift_d = {sdi, shift_q[WIDTH-1:1]};
      end
   end

`ifdef SER_RX_PARITY_EN
   // Even parity: XOR over the data word and the parity bit must be 0.
   logic parity_ok;
   always_comb begin
      parity_ok = ~((^shift_q) ^ sdi);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_SHIFT;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_SHIFT: begin
               if (start) begin
                  // A new start mid-frame aborts the partial frame and restarts
                  // reception; this edge belongs to the new start pulse.
                  err_q   <= 1'b1;
                  cnt_q   <= '0;
                  shift_q <= '0;
               end else if (cnt_q == LAST_CNT) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
`ifdef SER_RX_PARITY_EN
                  // shift_q already holds the data word; sdi is the parity bit.
                  if (parity_ok) begin
                     dout_q  <= shift_q;
                     valid_q <= 1'b1;
                  end else begin
                     err_q   <= 1'b1;
                  end
`else
                  shift_q <= shift_d;
                  dout_q  <= shift_d;
                  valid_q <= 1'b1;
`endif
               end else begin
                  shift_q <= shift_d;
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign err   = err_q;

endmodule
